// File: rtl/cskip_sub_serial.sv
// Block-serial subtractor: D = A + ~B + 1, one 4-bit carry-skip block per clock, LSB first.
// Valid/ready on both sides; reports borrow, signed overflow and number of skipped blocks.
module cskip_sub_serial #(
    parameter int WIDTH = 12,
    localparam int NBLK = WIDTH / 4,
    localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1,
    localparam int SKW = $clog2(NBLK + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf,
    output logic [SKW-1:0]   o_skip_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] minuend_q, minuend_d;
    logic [WIDTH-1:0] subN_q, subN_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SKW-1:0]   skipCnt_q, skipCnt_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    int               blkBase;
    logic [3:0]       blkA, blkB, blkSum;
    logic             rippleC, blkProp, carryNext;

    // State register; reset aborts any operation in flight and clears all results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            minuend_q <= '0;
            subN_q    <= '0;
            diff_q    <= '0;
            carry_q   <= 1'b1;
            idx_q     <= '0;
            skipCnt_q <= '0;
            borrow_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            minuend_q <= minuend_d;
            subN_q    <= subN_d;
            diff_q    <= diff_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            skipCnt_q <= skipCnt_d;
            borrow_q  <= borrow_d;
            ovf_q     <= ovf_d;
        end
    end

    // Current block: ripple sum plus the skip decision that bypasses the ripple chain.
    always_comb begin
        blkBase = int'(idx_q) * 4;
        blkA    = minuend_q[blkBase +: 4];
        blkB    = subN_q[blkBase +: 4];
        blkSum  = '0;
        rippleC = carry_q;
        for (int i = 0; i < 4; i++) begin
            blkSum[i] = blkA[i] ^ blkB[i] ^ rippleC;
            rippleC   = (blkA[i] & blkB[i]) | (rippleC & (blkA[i] ^ blkB[i]));
        end
        blkProp   = &(blkA ^ blkB);
        carryNext = blkProp ? carry_q : rippleC;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        minuend_d = minuend_q;
        subN_d    = subN_q;
        diff_d    = diff_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        skipCnt_d = skipCnt_q;
        borrow_d  = borrow_q;
        ovf_d     = ovf_q;
        o_ready   = 1'b0;
        o_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    minuend_d = i_minuend;
                    subN_d    = ~i_subtrahend;
                    carry_d   = 1'b1;
                    idx_d     = '0;
                    skipCnt_d = '0;
                    diff_d    = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                diff_d[blkBase +: 4] = blkSum;
                carry_d = carryNext;
                if (blkProp) begin
                    skipCnt_d = skipCnt_q + SKW'(1);
                end
                if (idx_q == IW'(NBLK - 1)) begin
                    idx_d    = '0;
                    borrow_d = ~carryNext;
                    // Subtrahend sign is the inverse of the stored ~B top bit.
                    ovf_d    = (minuend_q[WIDTH-1] != ~subN_q[WIDTH-1]) &&
                               (blkSum[3] != minuend_q[WIDTH-1]);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_diff     = diff_q;
    assign o_borrow   = borrow_q;
    assign o_ovf      = ovf_q;
    assign o_skip_cnt = skipCnt_q;

endmodule
